// File: rtl/pdm_demodulator.sv
// PDM receiver: bit-clock generator, input sampler and 2nd-order CIC decimator.
// Define PDM_SYNC_EN to insert a 2-flop synchroniser on pdm_in for asynchronous sources.
module pdm_demodulator #(
  parameter int CLK_DIV = 40,
  parameter int DECIM   = 64,
  parameter int OUT_W   = 10
) (
  input  logic             CLK100MHZ,
  input  logic             ck_rst,
  input  logic             pdm_in,
  output logic             pdm_clk,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid,
  output logic             clip
);
  localparam int LD = $clog2(DECIM);
  localparam int W  = 2*LD + 1;
  localparam int SH = 2*LD - OUT_W;
  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [LD-1:0]    dec_cnt_q;
  logic [W-1:0]     i1_q, i2_q, d1_q, d2_q;
  logic [W-1:0]     i1_d, i2_d, c1, c2, y;
  logic             warm_q, pdm_clk_q, valid_q, clip_q;
  logic [OUT_W-1:0] sample_q;
  logic             bit_stb, fire, x, sat;

`ifdef PDM_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge CLK100MHZ) begin
    if (ck_rst) sync_q <= '0;
    else        sync_q <= {sync_q[0], pdm_in};
  end
  assign x = sync_q[1];
`else
  assign x = pdm_in;
`endif

  assign bit_stb   = (div_cnt_q == DW'(CLK_DIV-1));
  assign div_cnt_d = bit_stb ? '0 : div_cnt_q + DW'(1);
  assign fire      = bit_stb && (dec_cnt_q == LD'(DECIM-1));

  // Integrators wrap freely; the combs cancel the wrap exactly.
  assign i1_d = i1_q + W'(x);
  assign i2_d = i2_q + i1_d;
  assign c1   = i2_d - d1_q;
  assign c2   = c1 - d2_q;
  assign y    = c2 >> SH;
  assign sat  = |y[W-1:OUT_W];

  always_ff @(posedge CLK100MHZ) begin
    if (ck_rst) begin
      div_cnt_q <= '0;
      dec_cnt_q <= '0;
      i1_q      <= '0;
      i2_q      <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      warm_q    <= 1'b0;
      pdm_clk_q <= 1'b0;
      valid_q   <= 1'b0;
      clip_q    <= 1'b0;
      sample_q  <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pdm_clk_q <= (div_cnt_d >= DW'(CLK_DIV/2));
      valid_q   <= 1'b0;
      if (bit_stb) begin
        dec_cnt_q <= dec_cnt_q + LD'(1);
        i1_q      <= i1_d;
        i2_q      <= i2_d;
      end
      // First firing after reset only primes the comb delays.
      if (fire) begin
        d1_q   <= i2_d;
        d2_q   <= c1;
        warm_q <= 1'b1;
        if (warm_q) begin
          valid_q  <= 1'b1;
          sample_q <= sat ? '1 : y[OUT_W-1:0];
          clip_q   <= sat;
        end
      end
    end
  end

  assign pdm_clk      = pdm_clk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign clip         = clip_q;
endmodule

// File: tb/tb_pdm_demodulator.sv
// Bench for pdm_demodulator: per-cycle check against a triangular-window CIC model
// plus literal expectations for each directed pattern.
`timescale 1ns/1ps
module tb_pdm_demodulator;
  localparam int CLK_DIV = 40;
  localparam int DECIM   = 64;
  localparam int OUT_W   = 10;
  localparam int HALF    = CLK_DIV/2;

  logic             CLK100MHZ = 1'b0;
  logic             ck_rst = 1'b1;
  logic             pdm_in = 1'b0;
  logic             pdm_clk, sample_valid, clip;
  logic [OUT_W-1:0] sample;

  pdm_demodulator #(.CLK_DIV(CLK_DIV), .DECIM(DECIM), .OUT_W(OUT_W)) dut (
    .CLK100MHZ(CLK100MHZ), .ck_rst(ck_rst), .pdm_in(pdm_in),
    .pdm_clk(pdm_clk), .sample(sample), .sample_valid(sample_valid), .clip(clip)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Impulse response of a 2nd-order CIC: two length-DECIM boxcars convolved.
  function automatic int h(input int k);
    return (k < DECIM) ? k + 1 : 2*DECIM - 1 - k;
  endfunction

  function automatic logic pat(input int mode, input int j);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (j % 2) == 1;
      3:       return (j % 4) == 1;
      4:       return j > 2*DECIM;
      default: return 1'b0;
    endcase
  endfunction

  // Model: n counts clock edges since reset release; bits collected every CLK_DIV edges.
  int n = 0;
  int bits[$];
  int exp_valid = 0, exp_sample = 0, exp_clip = 0;
  bit chk_en = 1'b0;
  int log_n[$], log_s[$], log_c[$];

  always @(posedge CLK100MHZ) begin
    if (ck_rst) begin
      n = 0;
      bits.delete();
      exp_valid = 0; exp_sample = 0; exp_clip = 0;
    end else begin
      n++;
      exp_valid = 0;
      if (n % CLK_DIV == 0) begin
        int m, acc, y;
        bits.push_back(int'(pdm_in));
        m = bits.size();
        if (m % DECIM == 0 && m >= 2*DECIM) begin
          acc = 0;
          for (int k = 0; k < 2*DECIM; k++) acc += h(k) * bits[m-1-k];
          y = acc >> 2;
          exp_valid = 1;
          if (y > (1 << OUT_W) - 1) begin exp_sample = (1 << OUT_W) - 1; exp_clip = 1; end
          else begin exp_sample = y; exp_clip = 0; end
        end
      end
    end
  end

  always @(negedge CLK100MHZ) begin
    if (chk_en) begin
      chk("pdm_clk", int'(pdm_clk), int'((n % CLK_DIV) >= HALF));
      chk("sample_valid", int'(sample_valid), exp_valid);
      chk("sample", int'(sample), exp_sample);
      chk("clip", int'(clip), exp_clip);
      if (sample_valid) begin
        log_n.push_back(n); log_s.push_back(int'(sample)); log_c.push_back(int'(clip));
      end
    end
  end

  task automatic start(input int mode);
    @(negedge CLK100MHZ);
    ck_rst = 1'b1;
    pdm_in = pat(mode, 1);
    @(negedge CLK100MHZ);
    chk_en = 1'b1;
    @(negedge CLK100MHZ);
    log_n.delete(); log_s.delete(); log_c.delete();
    ck_rst = 1'b0;
  endtask

  task automatic drive(input int mode, input int nbits);
    for (int e = 1; e <= nbits*CLK_DIV + 2; e++) begin
      @(negedge CLK100MHZ);
      if (e % CLK_DIV == HALF) pdm_in = pat(mode, e/CLK_DIV + 1);
    end
  endtask

  task automatic expect_log(input string name, input int idx, input int en, input int es, input int ec);
    if (idx < log_n.size()) begin
      chk({name, "_time"}, log_n[idx], en);
      chk({name, "_sample"}, log_s[idx], es);
      chk({name, "_clip"}, log_c[idx], ec);
    end else begin
      chk({name, "_missing"}, log_n.size(), idx + 1);
    end
  endtask

  initial begin
    // 1: zeros
    start(0); drive(0, 3*DECIM);
    chk("zeros_count", log_n.size(), 2);
    expect_log("zeros0", 0, 5120, 0, 0);
    expect_log("zeros1", 1, 7680, 0, 0);
    // 2: ones saturate
    start(1); drive(1, 3*DECIM);
    expect_log("ones0", 0, 5120, 1023, 1);
    expect_log("ones1", 1, 7680, 1023, 1);
    // 3: alternating 1,0
    start(2); drive(2, 3*DECIM);
    expect_log("alt0", 0, 5120, 512, 0);
    expect_log("alt1", 1, 7680, 512, 0);
    // 4: 1,0,0,0
    start(3); drive(3, 3*DECIM);
    expect_log("quarter0", 0, 5120, 256, 0);
    expect_log("quarter1", 1, 7680, 256, 0);
    // 5: step 0->1 on a decimation boundary
    start(4); drive(4, 5*DECIM);
    chk("step_count", log_n.size(), 4);
    expect_log("step0", 0, 5120, 0, 0);
    expect_log("step1", 1, 7680, 520, 0);
    expect_log("step2", 2, 10240, 1023, 1);
    expect_log("step3", 3, 12800, 1023, 1);
    // 6: one-cycle reset mid-period in the ones stream
    start(1); drive(1, 150);
    expect_log("prerst", 0, 5120, 1023, 1);
    @(negedge CLK100MHZ);
    ck_rst = 1'b1;
    @(posedge CLK100MHZ); #1;
    chk("rst_pdm_clk", int'(pdm_clk), 0);
    chk("rst_sample", int'(sample), 0);
    chk("rst_clip", int'(clip), 0);
    chk("rst_valid", int'(sample_valid), 0);
    @(negedge CLK100MHZ);
    log_n.delete(); log_s.delete(); log_c.delete();
    ck_rst = 1'b0;
    drive(1, 2*DECIM);
    chk("postrst_count", log_n.size(), 1);
    expect_log("postrst0", 0, 5120, 1023, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1);
  end
endmodule
